// File: rtl/interrupt_factor_ctrl_if.sv
// CPU data-memory bus slice seen by the interrupt factor/mask register window.
interface interrupt_factor_ctrl_if;
   logic [11:0] bus_addr;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [3:0]  bus_data_in;
   logic [3:0]  bus_data_out;
   logic        addr_hit;

   modport master (
      output bus_addr, mem_read_en, mem_write_en, bus_data_in,
      input  bus_data_out, addr_hit
   );

   modport slave (
      input  bus_addr, mem_read_en, mem_write_en, bus_data_in,
      output bus_data_out, addr_hit
   );
endinterface

// File: rtl/interrupt_factor_ctrl.sv
// Interrupt factor (edge-latched, read-clear) and mask registers in an 8-nibble window.
// Optional macro INTERRUPT_SRC_SYNC_EN adds a two-flop synchronizer on src_level.
module interrupt_factor_ctrl #(
   parameter logic [11:0] BASE_ADDR = 12'hF00,
   parameter int          NUM_SRC   = 15
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clk_en,
   input  logic [NUM_SRC-1:0]   src_level,
   interrupt_factor_ctrl_if.slave bus,
   output logic [NUM_SRC-1:0]   interrupt_req
);

   logic [NUM_SRC-1:0] factor;
   logic [NUM_SRC-1:0] mask;
   logic [NUM_SRC-1:0] src_prev;
   logic [NUM_SRC-1:0] src_sampled;

   logic [NUM_SRC-1:0] factor_next;
   logic [NUM_SRC-1:0] mask_next;
   logic [NUM_SRC-1:0] rise;

   logic [12:0] addr_ext;
   logic [12:0] window_lo;
   logic [12:0] window_hi;
   logic        hit;
   logic [2:0]  offset;
   logic [1:0]  nib;
   logic        is_mask;

   logic [15:0] factor_pad;
   logic [15:0] mask_pad;
   logic [15:0] read_word;
   logic [15:0] nib_sel;
   logic [15:0] clear_bits;
   logic [15:0] write_bits;
   logic [15:0] mask_wr_pad;
   logic [3:0]  read_nibble;

`ifdef INTERRUPT_SRC_SYNC_EN
   logic [NUM_SRC-1:0] sync_q1;
   logic [NUM_SRC-1:0] sync_q2;

   // Synchronizer runs on every clk so metastability settling is independent of clk_en.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= src_level;
         sync_q2 <= sync_q1;
      end
   end

   assign src_sampled = sync_q2;
`else
   assign src_sampled = src_level;
`endif

   // 13-bit compare keeps a window near the top of the address space from wrapping.
   always_comb begin
      addr_ext  = {1'b0, bus.bus_addr};
      window_lo = {1'b0, BASE_ADDR};
      window_hi = window_lo + 13'd7;
      hit       = (addr_ext >= window_lo) && (addr_ext <= window_hi);
      offset    = bus.bus_addr[2:0] - BASE_ADDR[2:0];
      nib       = offset[1:0];
      is_mask   = offset[2];
   end

   always_comb begin
      factor_pad                = '0;
      mask_pad                  = '0;
      factor_pad[NUM_SRC-1:0]   = factor;
      mask_pad[NUM_SRC-1:0]     = mask;
      read_word                 = is_mask ? mask_pad : factor_pad;
      read_nibble               = 4'h0;
      case (nib)
         2'd0: read_nibble = read_word[3:0];
         2'd1: read_nibble = read_word[7:4];
         2'd2: read_nibble = read_word[11:8];
         2'd3: read_nibble = read_word[15:12];
         default: read_nibble = 4'h0;
      endcase
   end

   assign bus.addr_hit     = hit;
   assign bus.bus_data_out = hit ? read_nibble : 4'h0;
   assign interrupt_req    = factor & mask;

   // A new rising edge is OR-ed in after the read-clear so a same-edge set wins.
   always_comb begin
      nib_sel     = 16'h000F << {nib, 2'b00};
      clear_bits  = (bus.mem_read_en && hit && !is_mask) ? nib_sel : 16'h0000;
      write_bits  = {12'h000, bus.bus_data_in} << {nib, 2'b00};
      mask_wr_pad = (mask_pad & ~nib_sel) | (write_bits & nib_sel);
      rise        = src_sampled & ~src_prev;
      factor_next = (factor & ~clear_bits[NUM_SRC-1:0]) | rise;
      mask_next   = mask;
      if (bus.mem_write_en && hit && is_mask) begin
         mask_next = mask_wr_pad[NUM_SRC-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         factor   <= '0;
         mask     <= '0;
         src_prev <= '0;
      end else if (clk_en) begin
         factor   <= factor_next;
         mask     <= mask_next;
         src_prev <= src_sampled;
      end
   end

endmodule

// File: doc/interrupt_factor_ctrl.md
INTERRUPT_FACTOR_CTRL -- requirements
Module: interrupt_factor_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 12'hF00; 12-bit base address of the 8-nibble register window.
REQ-002 SHALL have parameter NUM_SRC, default 15; number of interrupt sources (fixed at 15, matches the microcode interrupt vector width).
REQ-003 clk  input  1  system clock; the block uses one clock.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 clk_en  input  1  CPU-rate enable; all state updates occur only when it is high.
REQ-006 src_level  input  15  raw interrupt source levels; bit 14 is the highest priority.
REQ-007 bus_addr  input  12  CPU data-memory address.
REQ-008 mem_read_en  input  1  CPU read strobe.
REQ-009 mem_write_en  input  1  CPU write strobe.
REQ-010 bus_data_in  input  4  CPU write nibble.
REQ-011 bus_data_out  output  4  read nibble; 0 when the address does not hit.
REQ-012 addr_hit  output  1  bus_addr is within BASE_ADDR..BASE_ADDR+7.
REQ-013 interrupt_req  output  15  per-source request = factor AND mask; feeds microcode interrupt_req.

Function
REQ-014 SHALL hold a 15-bit factor register and a 15-bit mask register.
- Nibble g (g=0..3) covers bits 4g..4g+3.
- Bit 15 does not exist; it reads 0 and ignores writes.
REQ-015 Register map:
- BASE+g (g=0..3): factor nibble g; read-clear; writes are ignored.
- BASE+4+g: mask nibble g; read/write.
REQ-016 Edge detection: on each clk_en, the block samples src_level into src_prev. A 0->1 transition between consecutive samples sets factor[i].
REQ-017 Read-clear: a read of a factor nibble presents the current value on bus_data_out in the same cycle, combinationally from bus_addr. All four bits of that nibble clear at the next clk_en edge where mem_read_en and addr_hit are high.
REQ-018 Simultaneous set and clear on the same bit at the same clk_en edge: set wins, and the bit stays 1.
REQ-019 Mask write: at a clk_en edge with mem_write_en and a mask address, mask nibble g takes bus_data_in. The new mask affects interrupt_req from the next cycle.
REQ-020 interrupt_req SHALL be combinational from the registered factor and mask, with zero additional latency.
REQ-021 Factor bits SHALL set regardless of the mask. Unmasking a pending factor raises interrupt_req immediately.
REQ-022 mem_read_en and mem_write_en asserted together: the write applies to a mask address; the read-clear applies to a factor address. A single address cannot be both.
REQ-023 Addresses outside the window: no state change, bus_data_out=0, addr_hit=0.
REQ-024 When clk_en is low, nothing changes, including edge-detect history; outputs remain combinational.
REQ-025 A level held high SHALL produce exactly one factor set. It needs a fall and a new rise to set again.

Reset
REQ-026 reset_n low SHALL asynchronously clear factor, mask and src_prev to 0; interrupt_req=0, bus_data_out=0 with no hit.
REQ-027 After reset is released, a source already high at the first clk_en sample SHALL set its factor, because src_prev is 0.
REQ-028 Reset asserted mid-read or mid-write SHALL abort the access; the pending clear or write is not applied.

Configuration
REQ-029 Macro INTERRUPT_SRC_SYNC_EN:
- Defined: each src_level bit passes through a two-flop synchronizer clocked on clk (not gated by clk_en, reset to 0) before edge detection. This adds 2 clk of latency.
- Undefined: src_level feeds edge detection directly.

Verification
REQ-030 Reset, raise src_level[3] for one clk_en, mask nibble0=4'h8 -> factor nibble0 reads 4'h8; interrupt_req=15'h0008; next read returns 4'h0.
REQ-031 Hold src_level[14] high for 10 clk_en with mask nibble3=4'h4 -> interrupt_req[14] set once. Read BASE+3 returns 4'h4, then 4'h0 while the level remains high.
REQ-032 Rising edge on src_level[5] in the same clk_en as a read of BASE+1 -> the read returns the old value (0); factor[5] remains 1 (set wins).
REQ-033 factor[0] pending with mask 0 -> interrupt_req=0. Write BASE+4=4'h1 -> interrupt_req[0]=1 the next cycle.
REQ-034 Write 4'hF to BASE+7, then read it -> returns 4'h7 (bit 15 absent). Access at BASE+8 -> addr_hit=0, data 0, no state change.
REQ-035 Assert reset_n low asynchronously mid-cycle with factors and mask set -> all outputs 0 immediately. Build with INTERRUPT_SRC_SYNC_EN -> factor set delayed 2 clk relative to the direct build.
